// File: rtl/divu_sequencer_pkg.sv
// Shared definitions for the DIVU sequencer: ALU opcodes,
// FSM state encoding and the fixed operation latency.
package divu_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SRL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/divu_sequencer_step.sv
// Team ALU plus one restoring-division step built from two
// ALU instances (trial subtract and unsigned compare).
import divu_sequencer_pkg::*;

module divu_alu #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
) (
  input  logic [2:0]       ALUOperation,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic [SH_W-1:0]  Shamt,
  output logic [WIDTH-1:0] ALUResult
);

  // Operation select; set-on-less-than compares unsigned
  always_comb begin
    ALUResult = '0;
    case (ALUOperation)
      ALU_AND: ALUResult = DataA & DataB;
      ALU_OR:  ALUResult = DataA | DataB;
      ALU_ADD: ALUResult = DataA + DataB;
      ALU_SUB: ALUResult = DataA - DataB;
      ALU_SLT: ALUResult = {{(WIDTH-1){1'b0}}, DataA < DataB};
      ALU_SRL: ALUResult = DataB >> Shamt;
      default: ALUResult = '0;
    endcase
  end

endmodule

module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   w_p;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_slt;
  logic             w_ge;
  logic             w_unused;

  // R never exceeds the divisor, so its top bit is always zero
  assign w_unused = i_r[WIDTH];
  assign w_p      = {i_r[WIDTH-1:0], i_q[WIDTH-1]};

  divu_alu #(.WIDTH(WIDTH), .SH_W(SH_W)) u_sub (
    .ALUOperation (ALU_SUB),
    .DataA        (w_p[WIDTH-1:0]),
    .DataB        (i_d),
    .Shamt        (SH_W'(0)),
    .ALUResult    (w_sub)
  );

  divu_alu #(.WIDTH(WIDTH), .SH_W(SH_W)) u_cmp (
    .ALUOperation (ALU_SLT),
    .DataA        (w_p[WIDTH-1:0]),
    .DataB        (i_d),
    .Shamt        (SH_W'(0)),
    .ALUResult    (w_slt)
  );

  // Carry-out bit of P means P already exceeds any divisor
  assign w_ge = w_p[WIDTH] | (w_slt == '0);
  assign o_r  = w_ge ? {1'b0, w_sub} : w_p;
  assign o_q  = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divider controller (DIVU) for EX stage.
// One restoring step per cycle; Busy stalls the pipeline.
import divu_sequencer_pkg::*;

module divu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic             w_step;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  assign w_zero   = (Divisor == '0);
  assign w_accept = Start & ~Flush & (r_state != ST_CALC);
  assign w_step   = (r_state == ST_CALC) & ~Flush;
  assign w_last   = w_step & (r_cnt == CNT_W'(WIDTH-1));

  // Next-state logic; flush wins over everything else
  always_comb begin
    w_state_nxt = r_state;
    if (Flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start)
            w_state_nxt = w_zero ? ST_DONE : ST_CALC;
          else
            w_state_nxt = ST_IDLE;
        end
        ST_CALC: begin
          if (r_cnt == CNT_W'(WIDTH-1))
            w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture and one division step per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_r   <= '0;
      r_q   <= Dividend;
      r_d   <= Divisor;
      r_cnt <= '0;
    end else if (w_step) begin
      r_r   <= w_r_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers load only when entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept & w_zero) begin
      r_quot <= '1;
      r_rem  <= Dividend;
      r_dz   <= 1'b1;
    end else if (w_last) begin
      r_quot <= w_q_nxt;
      r_rem  <= w_r_nxt[WIDTH-1:0];
      r_dz   <= 1'b0;
    end
  end

  assign Busy      = (r_state == ST_CALC);
  assign Done      = (r_state == ST_DONE);
  assign DivZero   = r_dz;
  assign Quotient  = r_quot;
  assign Remainder = r_rem;

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: arithmetic model
// compared every cycle, plus directed literal checks.
module tb_divu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Quotient;
  logic [31:0] Remainder;

  int checks = 0;
  int errors = 0;

  divu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Flush     (Flush),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles and final results
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic        m_dz = 1'b0;
  logic [31:0] m_pq = '0;
  logic [31:0] m_pr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (Flush) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q    = m_pq;
          m_r    = m_pr;
          m_dz   = 1'b0;
        end
      end else if (Start) begin
        if (Divisor == 0) begin
          m_done = 1'b1;
          m_q    = 32'hFFFF_FFFF;
          m_r    = Dividend;
          m_dz   = 1'b1;
        end else begin
          m_left = 32;
          m_pq   = Dividend / Divisor;
          m_pr   = Dividend % Divisor;
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the edge
  always @(negedge clk) begin
    chk("busy", {31'd0, Busy}, {31'd0, m_left > 0});
    chk("done", {31'd0, Done}, {31'd0, m_done});
    chk("divzero", {31'd0, DivZero}, {31'd0, m_dz});
    chk("quotient", Quotient, m_q);
    chk("remainder", Remainder, m_r);
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    Dividend = a;
    Divisor = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Cycle n is the n-th cycle after the accept edge
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int dcount;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_quot", Quotient, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    rst = 1'b0;

    start_op(32'd100, 32'd7);
    chk("busy_first", {31'd0, Busy}, 32'd1);
    wait_done(1, n);
    chk("lat_100_7", n, 32'd33);
    chk("q_100_7", Quotient, 32'd14);
    chk("r_100_7", Remainder, 32'd2);

    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done(1, n);
    chk("q_max_1", Quotient, 32'hFFFF_FFFF);
    chk("r_max_1", Remainder, 32'd0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n);
    chk("q_msb_max", Quotient, 32'd0);
    chk("r_msb_max", Remainder, 32'h8000_0000);

    start_op(32'd5, 32'd0);
    wait_done(1, n);
    chk("lat_div0", n, 32'd1);
    chk("busy_div0", {31'd0, Busy}, 32'd0);
    chk("q_div0", Quotient, 32'hFFFF_FFFF);
    chk("r_div0", Remainder, 32'd5);
    chk("dz_div0", {31'd0, DivZero}, 32'd1);

    start_op(32'd9, 32'd3);
    wait_done(1, n);
    chk("q_9_3", Quotient, 32'd3);
    chk("r_9_3", Remainder, 32'd0);
    chk("dz_9_3", {31'd0, DivZero}, 32'd0);

    // Flush in cycle accept+10
    start_op(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush_busy", {31'd0, Busy}, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dcount++;
    end
    chk("flush_nodone", dcount, 32'd0);
    chk("flush_q", Quotient, 32'd3);

    // Start together with Flush is dropped
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1;
    Dividend = 32'd50; Divisor = 32'd5;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    chk("sf_busy", {31'd0, Busy}, 32'd0);
    chk("sf_done", {31'd0, Done}, 32'd0);

    // Start during CALC ignored, then back-to-back in DONE
    start_op(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    Start = 1'b1;
    Dividend = 32'd50; Divisor = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    wait_done(6, n);
    chk("lat_ign", n, 32'd33);
    chk("q_ign", Quotient, 32'd14);
    chk("r_ign", Remainder, 32'd2);
    Start = 1'b1;
    Dividend = 32'd50; Divisor = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    chk("b2b_busy", {31'd0, Busy}, 32'd1);
    wait_done(1, n);
    chk("lat_b2b", n, 32'd33);
    chk("q_50_5", Quotient, 32'd10);
    chk("r_50_5", Remainder, 32'd0);

    // Asynchronous reset mid-CALC in cycle accept+20
    start_op(32'd100, 32'd7);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    chk("arst_q", Quotient, 32'd0);
    chk("arst_r", Remainder, 32'd0);
    chk("arst_dz", {31'd0, DivZero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dcount++;
    end
    chk("arst_nodone", dcount, 32'd0);

    start_op(32'd7, 32'd2);
    wait_done(1, n);
    chk("lat_7_2", n, 32'd33);
    chk("q_7_2", Quotient, 32'd3);
    chk("r_7_2", Remainder, 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divu_sequencer.md
Name: divu_sequencer

Overview:
- Multi-cycle unsigned 32-bit divider controller for the EX stage of the pipelined MIPS core; executes DIVU.
- Sequences one restoring-division step per cycle: trial subtract plus unsigned compare, through two instances of the team ALU.
- Provides Busy to the hazard unit so the pipeline stalls until the quotient and remainder are written to HI/LO.

Parameters:
- WIDTH, 32, operand/result width
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Start  input  1  request; accepted only in IDLE or DONE
- Flush  input  1  abort current operation (branch/exception squash)
- Dividend  input  WIDTH  numerator; sampled on the accepted Start
- Divisor  input  WIDTH  denominator; sampled on the accepted Start
- Busy  output  1  operation in progress; stall request
- Done  output  1  one-cycle pulse when results become valid
- DivZero  output  1  last operation had Divisor==0; held with results
- Quotient  output  WIDTH  to LO; held until next accepted Start
- Remainder  output  WIDTH  to HI; held until next accepted Start

Behaviour:
- Reset (async, any state): state=IDLE; Busy=0, Done=0, DivZero=0, Quotient=0, Remainder=0, counter=0.
- States: IDLE, CALC, DONE.
  - IDLE/DONE + Start & !Flush & Divisor!=0 -> CALC.
  - IDLE/DONE + Start & !Flush & Divisor==0 -> DONE.
  - CALC & counter==WIDTH-1 -> DONE.
  - DONE with no Start -> IDLE.
  - Any state + Flush -> IDLE.
- Flush has priority over Start in the same cycle. A flush drops Busy next cycle, gives no Done, and leaves Quotient, Remainder and DivZero unchanged.
- Start while in CALC is ignored. Operands are not re-sampled.
- Accept edge T:
  - Registers: R=0 (WIDTH+1 bits), Q=Dividend, D=Divisor, counter=0.
  - Busy=1 from T+1 through the last CALC cycle.
- CALC step, one per cycle:
  - Shifted partial remainder P={R[WIDTH-1:0],Q[WIDTH-1]}, WIDTH+1 bits.
  - Subtract ALU: ALUOperation 3'b110 (sub), DataA=P[WIDTH-1:0], DataB=D.
  - Compare ALU: ALUOperation 3'b111 (slt), same operands. Result 0 means P[WIDTH-1:0]>=D unsigned.
  - Shamt tied to 0.
  - ge = P[WIDTH] | (slt result==0).
  - If ge: R=subtract result, zero-extended. Otherwise: R=P.
  - Q={Q[WIDTH-2:0],ge}. counter++.
- Latency: the CALC state covers edges T+1..T+WIDTH. Done=1 and results valid in cycle T+WIDTH+1 (33 cycles after accept). Busy=0 in that cycle.
- Divide by zero:
  - Done in cycle T+1, Busy never asserted.
  - Quotient=all ones, Remainder=Dividend, DivZero=1.
- Done is high for exactly one cycle. A back-to-back Start in the DONE cycle is accepted; its Busy rises on the next edge.
- Output registers load only on transition into DONE. DivZero is cleared on every non-zero-divisor completion.
- Reset asserted mid-CALC: immediate return to reset values, no Done.

Decomposition:
- Shared package:
  - ALU op constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111, ALU_SRL=3'b011.
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - DIV_LATENCY=33.
- One natural sub-module: divu_step. Combinational; wraps the two ALU instances and the ge/R/Q next-value logic. divu_sequencer holds the FSM, counter and registers.

Test Plan:
- Start, Dividend=100, Divisor=7 -> Busy for 32 cycles, Done at accept+33, Quotient=14, Remainder=2, DivZero=0.
- Dividend=0xFFFFFFFF, Divisor=1 -> Quotient=0xFFFFFFFF, Remainder=0. Dividend=0x80000000, Divisor=0xFFFFFFFF -> Quotient=0, Remainder=0x80000000. Both exercise the P[WIDTH] and compare paths.
- Dividend=5, Divisor=0 -> Done at accept+1, Busy stays 0, Quotient=0xFFFFFFFF, Remainder=5, DivZero=1. A following 9/3 -> Quotient=3, Remainder=0, DivZero=0.
- Start 100/7, Flush at accept+10 -> Busy=0 at accept+11, no Done ever; outputs keep the previous values. Start with Flush in the same cycle -> stays IDLE.
- Start 100/7, second Start 50/5 at accept+5 -> ignored, results 14/2. A Start in the DONE cycle with 50/5 -> Quotient=10, Remainder=0, Done 33 cycles later.
- Assert rst asynchronously (mid-clock) at accept+20 -> all outputs 0 immediately, IDLE after release; a fresh 7/2 gives Quotient=3, Remainder=1.
